// File: rtl/fib_scan_seq.sv
// Clocked scan controller for the 4-bit Fibonacci detector: sweeps lo..hi, tallies qualified hits.
// Optional FIB_SCAN_STALL_EN adds a ready_i input that stalls the sweep while low.
module fib_scan_seq #(
  parameter int unsigned CODE_W    = 4,
  parameter int unsigned CNT_W     = 5,
  parameter int unsigned VALID_MAX = 9
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [CODE_W-1:0] lo_i,
  input  logic [CODE_W-1:0] hi_i,
  input  logic              isfib_i,
`ifdef FIB_SCAN_STALL_EN
  input  logic              ready_i,
`endif
  output logic [CODE_W-1:0] code_o,
  output logic              code_valid_o,
  output logic              busy_o,
  output logic              done_o,
  output logic [CNT_W-1:0]  hit_cnt_o,
  output logic [CNT_W-1:0]  chk_cnt_o,
  output logic [CODE_W-1:0] last_hit_o
);

  typedef enum logic [1:0] {StIdle, StScan, StDone} state_e;

  localparam logic [CODE_W-1:0] ValidMax = CODE_W'(VALID_MAX);

  state_e             state_q, state_d;
  logic [CODE_W-1:0]  code_q, code_d;
  logic [CODE_W-1:0]  hi_q, hi_d;
  logic [CNT_W-1:0]   hit_cnt_q, hit_cnt_d;
  logic [CNT_W-1:0]   chk_cnt_q, chk_cnt_d;
  logic [CODE_W-1:0]  last_hit_q, last_hit_d;
  logic               advance;
  logic               hit;

`ifdef FIB_SCAN_STALL_EN
  assign advance = ready_i;
`else
  assign advance = 1'b1;
`endif

  // Range gate first so an undefined isfib above ValidMax is masked out.
  assign hit = (code_q <= ValidMax) && (isfib_i == 1'b1);

  always_comb begin
    state_d    = state_q;
    code_d     = code_q;
    hi_d       = hi_q;
    hit_cnt_d  = hit_cnt_q;
    chk_cnt_d  = chk_cnt_q;
    last_hit_d = last_hit_q;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          hi_d       = hi_i;
          code_d     = lo_i;
          hit_cnt_d  = '0;
          chk_cnt_d  = '0;
          last_hit_d = '0;
          state_d    = (lo_i <= hi_i) ? StScan : StDone;
        end
      end
      StScan: begin
        if (advance) begin
          chk_cnt_d = chk_cnt_q + CNT_W'(1);
          if (hit) begin
            hit_cnt_d  = hit_cnt_q + CNT_W'(1);
            last_hit_d = code_q;
          end
          // Compare before incrementing so hi at the top of the range never wraps.
          if (code_q == hi_q) begin
            state_d = StDone;
          end else begin
            code_d = code_q + CODE_W'(1);
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      code_q     <= '0;
      hi_q       <= '0;
      hit_cnt_q  <= '0;
      chk_cnt_q  <= '0;
      last_hit_q <= '0;
    end else begin
      state_q    <= state_d;
      code_q     <= code_d;
      hi_q       <= hi_d;
      hit_cnt_q  <= hit_cnt_d;
      chk_cnt_q  <= chk_cnt_d;
      last_hit_q <= last_hit_d;
    end
  end

  assign code_o       = code_q;
  assign code_valid_o = (state_q == StScan);
  assign busy_o       = (state_q != StIdle);
  assign done_o       = (state_q == StDone);
  assign hit_cnt_o    = hit_cnt_q;
  assign chk_cnt_o    = chk_cnt_q;
  assign last_hit_o   = last_hit_q;

endmodule

// File: tb/tb_fib_scan_seq.sv
// Directed bench for fib_scan_seq with a golden 4-bit Fibonacci detector model on the return path.
module tb_fib_scan_seq;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic       start_i = 1'b0;
  logic [3:0] lo_i = '0;
  logic [3:0] hi_i = '0;
  logic       isfib_i;
  logic       ready_i = 1'b1;
  logic [3:0] code_o;
  logic       code_valid_o;
  logic       busy_o;
  logic       done_o;
  logic [4:0] hit_cnt_o;
  logic [4:0] chk_cnt_o;
  logic [3:0] last_hit_o;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk_i = ~clk_i;

  // Golden detector; above 9 it answers 1 so any leak past the range gate shows as a hit.
  function automatic logic fib_model(input logic [3:0] c);
    case (c)
      4'd0, 4'd1, 4'd2, 4'd3, 4'd5, 4'd8: fib_model = 1'b1;
      4'd4, 4'd6, 4'd7, 4'd9:             fib_model = 1'b0;
      default:                            fib_model = 1'b1;
    endcase
  endfunction

  assign isfib_i = fib_model(code_o);

  fib_scan_seq dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .start_i      (start_i),
    .lo_i         (lo_i),
    .hi_i         (hi_i),
    .isfib_i      (isfib_i),
`ifdef FIB_SCAN_STALL_EN
    .ready_i      (ready_i),
`endif
    .code_o       (code_o),
    .code_valid_o (code_valid_o),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .hit_cnt_o    (hit_cnt_o),
    .chk_cnt_o    (chk_cnt_o),
    .last_hit_o   (last_hit_o)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Cycle 1 is the cycle after the edge that accepts start.
  task automatic run_scan(input string tag, input logic [3:0] lo, input logic [3:0] hi,
                          input int hold, input bit stall_en, input int exp_hit,
                          input int exp_chk, input int exp_last, input int exp_done_cyc);
    int cyc;
    int exp_code;
    int nvalid;
    int stalls;
    @(negedge clk_i);
    lo_i    = lo;
    hi_i    = hi;
    start_i = 1'b1;
    @(posedge clk_i);
    #1;
    if (hold > 0) begin
      lo_i = 4'd12;
      hi_i = 4'd13;
    end else begin
      start_i = 1'b0;
    end
    cyc      = 1;
    exp_code = int'(lo);
    nvalid   = 0;
    stalls   = 0;
    @(negedge clk_i);
    while (!done_o && cyc < 40) begin
      if (cyc >= hold) start_i = 1'b0;
      if (code_valid_o) begin
        nvalid++;
        check_val({tag, " code"}, 32'(code_o), 32'(exp_code));
        check_val({tag, " chk_run"}, 32'(chk_cnt_o), 32'(exp_code - int'(lo)));
        ready_i = !(stall_en && code_o == 4'd3 && stalls < 3);
        if (!ready_i) stalls++;
        else exp_code++;
      end
      @(negedge clk_i);
      cyc++;
    end
    ready_i = 1'b1;
    start_i = 1'b0;
    check_val({tag, " done"}, 32'(done_o), 32'd1);
    check_val({tag, " done_cyc"}, 32'(cyc), 32'(exp_done_cyc));
    check_val({tag, " valid_cycles"}, 32'(nvalid), 32'(exp_chk + 3 * int'(stall_en)));
    check_val({tag, " hit_cnt"}, 32'(hit_cnt_o), 32'(exp_hit));
    check_val({tag, " chk_cnt"}, 32'(chk_cnt_o), 32'(exp_chk));
    check_val({tag, " last_hit"}, 32'(last_hit_o), 32'(exp_last));
    @(negedge clk_i);
    check_val({tag, " done_pulse"}, 32'(done_o), 32'd0);
    check_val({tag, " idle"}, 32'(busy_o), 32'd0);
    check_val({tag, " hit_hold"}, 32'(hit_cnt_o), 32'(exp_hit));
  endtask

  initial begin
    int guard;
    repeat (2) @(negedge clk_i);
    check_val("rst code", 32'(code_o), 32'd0);
    check_val("rst flags", {29'd0, code_valid_o, busy_o, done_o}, 32'd0);
    check_val("rst cnts", {22'd0, hit_cnt_o, chk_cnt_o}, 32'd0);
    check_val("rst last", 32'(last_hit_o), 32'd0);
    rst_i = 1'b0;
    @(negedge clk_i);

    run_scan("full", 4'd0, 4'd9, 0, 1'b0, 6, 10, 8, 11);
    run_scan("masked", 4'd10, 4'd15, 0, 1'b0, 0, 6, 0, 7);
    check_val("masked nowrap", 32'(code_o), 32'd15);
    run_scan("single", 4'd5, 4'd5, 0, 1'b0, 1, 1, 5, 2);
    run_scan("empty", 4'd9, 4'd3, 0, 1'b0, 0, 0, 0, 1);
    run_scan("held_start", 4'd0, 4'd9, 3, 1'b0, 6, 10, 8, 11);

    // Abort at code 4 with an async reset between edges.
    @(negedge clk_i);
    lo_i    = 4'd0;
    hi_i    = 4'd9;
    start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    guard   = 0;
    while (code_o != 4'd4 && guard < 20) begin
      @(negedge clk_i);
      guard++;
    end
    check_val("abort reach4", 32'(code_o), 32'd4);
    rst_i = 1'b1;
    #1;
    check_val("abort code", 32'(code_o), 32'd0);
    check_val("abort flags", {29'd0, code_valid_o, busy_o, done_o}, 32'd0);
    check_val("abort cnts", {22'd0, hit_cnt_o, chk_cnt_o}, 32'd0);
    check_val("abort last", 32'(last_hit_o), 32'd0);
    @(negedge clk_i);
    check_val("abort nodone", 32'(done_o), 32'd0);
    rst_i = 1'b0;
    @(negedge clk_i);
    check_val("abort nodone2", 32'(done_o), 32'd0);
    run_scan("after_abort", 4'd0, 4'd9, 0, 1'b0, 6, 10, 8, 11);

`ifdef FIB_SCAN_STALL_EN
    run_scan("stall", 4'd0, 4'd9, 0, 1'b1, 6, 10, 8, 14);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fib_scan_seq.md
Name: fib_scan_seq

Overview:
- Sequential stimulus and accumulate stage directly upstream of the 4-bit Fibonacci detector.
- On start, steps a 4-bit code one value per cycle from lo to hi and drives it into the detector.
- Samples the detector's isfib answer for each code, counts hits and checked codes, records the last hit, then pulses done.
- Lets the combinational detector be exercised and summarised under a clocked controller.

Parameters:
CODE_W, 4, width of code / lo / hi (detector input width)
CNT_W, 5, width of hit_cnt and chk_cnt (must hold 2^CODE_W)
VALID_MAX, 9, largest code for which isfib is defined; codes above never count as hits

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous active-high reset
start  input  1  begin a scan; honoured only in IDLE
lo  input  CODE_W  first code of range; sampled on accepted start
hi  input  CODE_W  last code of range, inclusive; sampled on accepted start
isfib  input  1  detector response for current code (combinational return path)
code  output  CODE_W  value driven to detector input
code_valid  output  1  code is being evaluated this cycle
busy  output  1  state != IDLE
done  output  1  one-cycle pulse at scan end
hit_cnt  output  CNT_W  number of codes with qualified isfib=1
chk_cnt  output  CNT_W  number of codes evaluated
last_hit  output  CODE_W  largest code that was a hit (0 if none)

Behaviour:
- Reset (async, immediate):
  - state=IDLE; code=0; code_valid=0; busy=0; done=0; hit_cnt=0; chk_cnt=0; last_hit=0.
  - Reset mid-scan aborts without a done pulse.
- States are IDLE, SCAN, DONE.
- IDLE:
  - On start=1, register lo and hi, clear hit_cnt, chk_cnt and last_hit.
  - If lo<=hi: next state SCAN with code=lo. Otherwise: next state DONE (empty range, no codes evaluated).
  - Without start, previous results hold indefinitely.
- SCAN:
  - code_valid=1.
  - Each cycle, sample isfib for the current code.
  - Hit condition is code<=VALID_MAX AND isfib==1. Codes 10..15 are masked because the detector output is undefined (x) there; an x on isfib must never reach the counters.
  - On hit: hit_cnt+1 and last_hit=code.
  - chk_cnt+1 every evaluated cycle.
  - If code==hi: next state DONE and code holds. Otherwise code+1.
  - The comparison is made before the increment, so hi=15 never wraps code to 0.
- DONE: done=1 for exactly one cycle, code_valid=0, then IDLE. Counters hold.
- start while busy (SCAN or DONE) is ignored; lo and hi changes during a scan are ignored.
- Latency: start accepted at edge 0. For N=hi-lo+1 codes, SCAN occupies cycles 1..N and done is asserted in cycle N+1. Empty range gives done in cycle 1.
- Arithmetic: counters are unsigned CNT_W and cannot overflow (max 16 with defaults). code increments modulo 2^CODE_W but is gated by the hi compare.
- Results (hit_cnt, chk_cnt, last_hit) are valid from the done cycle until the next accepted start or reset.

Optional Feature:
- Macro FIB_SCAN_STALL_EN.
- Defined: adds input port ready (1 bit) after isfib.
  - In SCAN with ready=0, code holds, nothing is sampled or counted, and the state does not advance; code_valid stays 1.
  - With ready=1, behaviour is as above. ready is ignored outside SCAN.
  - Latency grows by the number of stalled SCAN cycles.
- Undefined: port absent; SCAN advances every cycle.

Test Plan:
- lo=0, hi=9, start 1 cycle, golden detector model -> code sweeps 0..9 in cycles 1..10; done in cycle 11; hit_cnt=6, chk_cnt=10, last_hit=8.
- lo=10, hi=15, model drives isfib=x or 1 for those codes -> hit_cnt=0, chk_cnt=6, last_hit=0; code stops at 15, no wrap to 0; done in cycle 7.
- lo=5, hi=5 -> single SCAN cycle with code=5; hit_cnt=1, chk_cnt=1, last_hit=5; done in cycle 2.
- lo=9, hi=3 -> code_valid never asserts; done in cycle 1; hit_cnt=0, chk_cnt=0. A start pulse held during a later scan is ignored.
- lo=0, hi=9, rst asserted mid-scan at code=4 -> all outputs 0 immediately (asynchronously, before next edge); no done; a new start then gives hit_cnt=6.
- FIB_SCAN_STALL_EN, lo=0, hi=9, ready low for 3 cycles at code=3 -> code holds at 3, chk_cnt stays 3; done in cycle 14; hit_cnt=6.
